ids_bus_arbiter: RTL and testbench
==================================

# ids_bus_arbiter

Two-requester arbiter for the shared data port of the IDS bus. It resolves contention between the core data interface (`req_dmem`/`gnt_dmem`) and the DMA engine (`req_dma`/`gnt_dma`). It issues registered, mutually exclusive grants and exposes the current owner so the bus can steer its address/data mux. An optional burst limiter preempts a long-running owner so neither the core nor the DMA can starve the other.

## Interface

Parameters:
- `MAX_BURST`, default 16: maximum consecutive granted cycles before forced handover. Only used with the burst limiter. Legal range is 1..2^CNT_W−1.
- `CNT_W`, default 5: width of the burst counter.

Ports:
- `i_clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_req_dmem` in 1: core data request, level, held until served.
- `o_gnt_dmem` out 1: core granted (registered).
- `i_req_dma` in 1: DMA request, level, held until served.
- `o_gnt_dma` out 1: DMA granted (registered).
- `o_owner` out 2: bus mux select. 2'b00 none, 2'b01 core, 2'b10 DMA. 2'b11 is never driven.
- `o_busy` out 1: high when `o_owner` != 2'b00.
- `o_preempt` out 1: one-cycle pulse on a limiter-forced handover.

## Operation

- FSM states:
  - IDLE: no grant.
  - CORE: `o_gnt_dmem`=1.
  - DMA: `o_gnt_dma`=1.
- Outputs are decoded from the state register only; there is no combinational path from request to grant.
- `last_dma` flag records the most recent owner. It resets to 1, so the core wins the first tie.

Transitions from IDLE:
- Only core requesting: go to CORE.
- Only DMA requesting: go to DMA.
- Both requesting: go to CORE if `last_dma`=1, else DMA.
- Neither requesting: stay in IDLE.

Transitions from CORE or DMA:
- Owner request still high: stay, unless a limiter preemption applies.
- Owner request low and the other requester high: switch directly to the other state, with no IDLE cycle.
- Both low: go to IDLE.
- `last_dma` updates on every entry into CORE (set to 0) or DMA (set to 1).

Invariants:
- `o_gnt_dmem` and `o_gnt_dma` are never both 1.
- `o_owner` always matches the grants.

A requester that drops its request before being granted is simply not granted. No pending state is stored.

Burst limiter (when compiled in):
- `burst_cnt` loads 1 on entry into CORE or DMA and increments on each further cycle in the same state. It saturates at MAX_BURST.
- Preemption: at an edge where `burst_cnt`==MAX_BURST and the non-owner request is high, switch to the other state and pulse `o_preempt` for one cycle.
- A preempted requester keeps its request high and is re-granted later through normal arbitration.
- If the non-owner is not requesting, the owner keeps the bus indefinitely and the counter stays saturated.

## Timing

Reset values (applied asynchronously while `i_rst_n`=0):
- state=IDLE
- `o_gnt_dmem`=0, `o_gnt_dma`=0
- `o_owner`=2'b00, `o_busy`=0, `o_preempt`=0
- `last_dma`=1, `burst_cnt`=0

Latency and handover:
- Grant latency: a request sampled high at edge N in IDLE gives a grant visible after edge N.
- Release: the owner's request sampled low at edge N drops its grant after edge N.
- Handover: with the other request high at the same edge N, the other grant rises after edge N. Zero dead cycles.

Burst limiter timing:
- An owner receives exactly MAX_BURST grant cycles before preemption.
- MAX_BURST=1 alternates owners every cycle under sustained dual requests.

Boundary cases:
- Owner drops its request at the same edge the limit is reached: this is a normal handover, and `o_preempt` stays 0.
- Reset asserted mid-burst: grants drop immediately without waiting for a clock edge. The first arbitration after reset release behaves as from reset, so the core wins a tie.

## Configuration

- Macro `IDS_ARB_BURST_LIMIT_EN`.
- Defined: the burst limiter, `burst_cnt` and `o_preempt` logic are present, as described above.
- Undefined:
  - No counter is present and `o_preempt` is tied 0.
  - An owner holds the bus for as long as its request stays high.
  - Round-robin applies only at IDLE ties and handovers.
  - The port list is unchanged.

## Test plan

- Reset: hold `i_rst_n`=0 with both requests high. Required: both grants 0, `o_owner`=00, `o_busy`=0. Release reset with both requests high. Required: `o_gnt_dmem`=1 one edge later.
- Single requester: pulse `i_req_dma` high for 3 cycles. Required: `o_gnt_dma` high for 3 cycles starting one edge later, `o_owner`=10, then IDLE.
- Tie and round-robin: both requests high from IDLE. The core is served first. The core drops its request after 2 grant cycles. Required: `o_gnt_dma` rises on the very next edge with no gap, and `o_owner` goes 01→10.
- Preemption with `IDS_ARB_BURST_LIMIT_EN` and MAX_BURST=4: both requests held high continuously.
  - Required: grants alternate CORE×4, DMA×4, CORE×4.
  - `o_preempt` pulses 1 cycle at each switch.
  - Never both grants high.
- No limiter (macro undefined), same stimulus. Required: the core holds the grant for the whole test, and `o_preempt` stays 0.
- Mid-burst reset: the DMA owns the bus, and `i_rst_n` is dropped between edges. Required: `o_gnt_dma` falls immediately. After reset release with both requests high, the core is granted first.

Source files
------------

// File: rtl/ids_bus_arbiter.sv
// Two-requester arbiter (core data port vs DMA) for the IDS bus shared data port.
// Define IDS_ARB_BURST_LIMIT_EN to build in the burst limiter (burst_cnt, o_preempt).
module ids_bus_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_dmem,
  output logic       o_gnt_dmem,
  input  logic       i_req_dma,
  output logic       o_gnt_dma,
  output logic [1:0] o_owner,
  output logic       o_busy,
  output logic       o_preempt
);

  // state   | meaning
  // --------+-------------------------------
  // ST_IDLE | no grant, bus parked
  // ST_CORE | core data interface owns bus
  // ST_DMA  | DMA engine owns bus
  // Encoding doubles as the owner mux select.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CORE = 2'b01,
    ST_DMA  = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_dma;

  if (MAX_BURST < 1 || MAX_BURST > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("ids_bus_arbiter: MAX_BURST out of range for CNT_W");
  end

`ifdef IDS_ARB_BURST_LIMIT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] burst_cnt;
  logic             at_limit;
  logic             take_over;
  logic             preempt;

  assign at_limit = (burst_cnt == CNT_MAX);
`endif

  always_comb begin
    state_nxt = state;
`ifdef IDS_ARB_BURST_LIMIT_EN
    take_over = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (i_req_dmem && (!i_req_dma || last_dma)) state_nxt = ST_CORE;
        else if (i_req_dma)                          state_nxt = ST_DMA;
      end
      ST_CORE: begin
        if (!i_req_dmem) begin
          state_nxt = i_req_dma ? ST_DMA : ST_IDLE;
        end
`ifdef IDS_ARB_BURST_LIMIT_EN
        else if (at_limit && i_req_dma) begin
          state_nxt = ST_DMA;
          take_over = 1'b1;
        end
`endif
      end
      ST_DMA: begin
        if (!i_req_dma) begin
          state_nxt = i_req_dmem ? ST_CORE : ST_IDLE;
        end
`ifdef IDS_ARB_BURST_LIMIT_EN
        else if (at_limit && i_req_dmem) begin
          state_nxt = ST_CORE;
          take_over = 1'b1;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      last_dma <= 1'b1;
`ifdef IDS_ARB_BURST_LIMIT_EN
      burst_cnt <= '0;
      preempt   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt != ST_IDLE && state_nxt != state) begin
        last_dma <= (state_nxt == ST_DMA);
      end
`ifdef IDS_ARB_BURST_LIMIT_EN
      preempt <= take_over;
      // Counter saturates so an uncontested owner can keep the bus forever.
      if (state_nxt == ST_IDLE)     burst_cnt <= '0;
      else if (state_nxt != state)  burst_cnt <= CNT_W'(1);
      else if (!at_limit)           burst_cnt <= burst_cnt + CNT_W'(1);
`endif
    end
  end

  assign o_gnt_dmem = (state == ST_CORE);
  assign o_gnt_dma  = (state == ST_DMA);
  assign o_owner    = state;
  assign o_busy     = (state != ST_IDLE);
`ifdef IDS_ARB_BURST_LIMIT_EN
  assign o_preempt  = preempt;
`else
  assign o_preempt  = 1'b0;
`endif

endmodule

// File: tb/tb_ids_bus_arbiter.sv
// Scoreboard bench for ids_bus_arbiter: directed scenarios plus random requests,
// checked against an owner/run-length reference model.
module tb_ids_bus_arbiter;
  localparam int MB = 4;
  localparam int CW = 5;
`ifdef IDS_ARB_BURST_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_dmem = 1'b0;
  logic       req_dma = 1'b0;
  logic       gnt_dmem;
  logic       gnt_dma;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;

  ids_bus_arbiter #(.MAX_BURST(MB), .CNT_W(CW)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req_dmem(req_dmem),
    .o_gnt_dmem(gnt_dmem),
    .i_req_dma(req_dma),
    .o_gnt_dma(gnt_dma),
    .o_owner(owner),
    .o_busy(busy),
    .o_preempt(preempt)
  );

  always #5 clk = ~clk;

  // {gnt_dmem, gnt_dma, owner[1:0], busy, preempt}
  typedef logic [5:0] obs_t;

  obs_t exp_q[$];
  obs_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Reference model: who owns the bus (0 none, 1 core, 2 DMA), who owned it
  // last, and how many consecutive cycles the current owner has held it.
  int m_own  = 0;
  int m_last = 2;
  int m_run  = 0;

  function automatic obs_t observe();
    return {gnt_dmem, gnt_dma, owner, busy, preempt};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b required %b (gd,ga,own,busy,pre) t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_own  = 0;
    m_last = 2;
    m_run  = 0;
  endtask

  task automatic model_step(input bit rc, input bit rd);
    int nxt;
    bit pre;
    bit mine;
    bit other;
    pre = 1'b0;
    if (m_own == 0) begin
      if (rc && rd) nxt = (m_last == 2) ? 1 : 2;
      else          nxt = rc ? 1 : (rd ? 2 : 0);
    end else begin
      mine  = (m_own == 1) ? rc : rd;
      other = (m_own == 1) ? rd : rc;
      if (!mine)                         nxt = other ? 3 - m_own : 0;
      else if (LIM && m_run >= MB && other) begin
        nxt = 3 - m_own;
        pre = 1'b1;
      end else                           nxt = m_own;
    end
    if (nxt == 0)           m_run = 0;
    else if (nxt != m_own)  m_run = 1;
    else                    m_run = m_run + 1;
    if (nxt != 0) m_last = nxt;
    m_own = nxt;
    exp_q.push_back({nxt == 1, nxt == 2, 2'(nxt), nxt != 0, pre});
  endtask

  // Requests change at the falling edge; model advances at the rising edge.
  task automatic cycle(input bit rc, input bit rd);
    req_dmem = rc;
    req_dma  = rd;
    @(posedge clk);
    model_step(rc, rd);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("mutex", {5'b0, gnt_dmem & gnt_dma}, 6'b0);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("outputs", observe(), mon_e);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    req_dmem = 1'b1;
    req_dma  = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("reset_hold", observe(), 6'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // First tie after reset goes to the core.
    cycle(1, 1);
    cycle(0, 0);
    cycle(0, 0);

    // Single DMA burst of three cycles.
    repeat (3) cycle(0, 1);
    repeat (2) cycle(0, 0);

    // Tie from idle (last owner DMA) then core drops after two grants.
    repeat (2) cycle(1, 1);
    repeat (2) cycle(0, 1);
    cycle(0, 0);

    // Sustained dual requests: limiter alternation or core hold.
    repeat (14) cycle(1, 1);
    repeat (2) cycle(0, 0);

    // Owner drops exactly when the limit is reached: plain handover.
    repeat (MB) cycle(1, 1);
    cycle(0, 1);
    repeat (2) cycle(0, 0);

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    repeat (2) cycle(0, 0);

    // Mid-burst reset while DMA owns the bus.
    repeat (3) cycle(0, 1);
    req_dmem = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("midburst_reset", observe(), 6'b0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    cycle(1, 1);
    cycle(1, 1);
    repeat (2) cycle(0, 0);

    @(negedge clk);
    #1 check("drain", {5'b0, exp_q.size() != 0}, 6'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
